// File: rtl/xmpl_dsp_cic.sv
// xmpl_dsp_cic: STAGES-order CIC decimator by DEC_R with per-session output framing.
// Integrators update on every accepted sample; the comb chain fires on the last sample of each group.
module xmpl_dsp_cic #(
   parameter  int unsigned IN_W      = 16,
   parameter  int unsigned STAGES    = 3,
   parameter  int unsigned DEC_R     = 8,
   parameter  int unsigned FRAME_LEN = 64,
   localparam int unsigned OUT_W     = IN_W + STAGES * $clog2(DEC_R)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_xmpl_dsp_cic_i,
   input  logic [IN_W-1:0]  din_i,
   input  logic             din_valid_i,
   output logic [OUT_W-1:0] dout_o,
   output logic             dout_valid_o,
   output logic             xmpl_dsp_cic_status_o,
   output logic             busy_o
);

   localparam int unsigned CNT_W  = $clog2(DEC_R);
   localparam int unsigned OCNT_W = $clog2(FRAME_LEN + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [OUT_W-1:0]   r_int [STAGES];
   logic [OUT_W-1:0]   r_dly [STAGES];
   logic [CNT_W-1:0]   r_dec_cnt;
   logic [OCNT_W-1:0]  r_out_cnt;
   logic [OUT_W-1:0]   r_dout;
   logic               r_dout_valid;
   logic               r_status;
   logic               r_busy;

   logic [OUT_W-1:0]   w_din_ext;
   logic [OUT_W-1:0]   w_int_nxt [STAGES];
   logic [OUT_W-1:0]   w_comb    [STAGES];

   // Integrator cascade uses the values being written this edge; combs chain off the last integrator.
   always_comb begin
      w_din_ext    = OUT_W'($signed(din_i));
      w_int_nxt[0] = r_int[0] + w_din_ext;
      for (int unsigned k = 1; k < STAGES; k++) begin
         w_int_nxt[k] = r_int[k] + w_int_nxt[k-1];
      end
      w_comb[0] = w_int_nxt[STAGES-1] - r_dly[0];
      for (int unsigned k = 1; k < STAGES; k++) begin
         w_comb[k] = w_comb[k-1] - r_dly[k];
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state      <= ST_IDLE;
         r_dec_cnt    <= '0;
         r_out_cnt    <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_status     <= 1'b0;
         r_busy       <= 1'b0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_int[k] <= '0;
            r_dly[k] <= '0;
         end
      end else begin
         r_dout_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // Datapath is held cleared here, so every session starts from zero state.
               r_dec_cnt <= '0;
               r_out_cnt <= '0;
               r_dout    <= '0;
               r_status  <= 1'b0;
               for (int unsigned k = 0; k < STAGES; k++) begin
                  r_int[k] <= '0;
                  r_dly[k] <= '0;
               end
               if (en_xmpl_dsp_cic_i) begin
                  r_state <= ST_RUN;
                  r_busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!en_xmpl_dsp_cic_i) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (din_valid_i) begin
                  for (int unsigned k = 0; k < STAGES; k++) begin
                     r_int[k] <= w_int_nxt[k];
                  end
                  if (r_dec_cnt == CNT_W'(DEC_R - 1)) begin
                     r_dec_cnt    <= '0;
                     r_dly[0]     <= w_int_nxt[STAGES-1];
                     for (int unsigned k = 1; k < STAGES; k++) begin
                        r_dly[k] <= w_comb[k-1];
                     end
                     r_dout       <= w_comb[STAGES-1];
                     r_dout_valid <= 1'b1;
                     r_out_cnt    <= r_out_cnt + OCNT_W'(1);
                     if (r_out_cnt == OCNT_W'(FRAME_LEN - 1)) begin
                        r_state  <= ST_DONE;
                        r_busy   <= 1'b0;
                        r_status <= 1'b1;
                     end
                  end else begin
                     r_dec_cnt <= r_dec_cnt + CNT_W'(1);
                  end
               end
            end
            ST_DONE: begin
               if (!en_xmpl_dsp_cic_i) begin
                  r_state  <= ST_IDLE;
                  r_status <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign dout_o                = r_dout;
   assign dout_valid_o          = r_dout_valid;
   assign xmpl_dsp_cic_status_o = r_status;
   assign busy_o                = r_busy;

endmodule

// File: tb/tb_xmpl_dsp_cic.sv
// Bench for xmpl_dsp_cic: table of input sessions plus hand-written abort/reset sequences,
// checked against an impulse-response convolution model through a timed scoreboard.
module tb_xmpl_dsp_cic;

   localparam int IN_W      = 16;
   localparam int STAGES    = 3;
   localparam int DEC_R     = 8;
   localparam int FRAME_LEN = 64;
   localparam int OUT_W     = 25;
   localparam int HLEN      = STAGES * (DEC_R - 1) + 1;

   typedef struct {
      logic [OUT_W-1:0] val;
      int               cyc;
      logic             st;
   } exp_t;

   typedef struct {
      string            name;
      int               din;
      int               gap;
      int               n_acc;
      int               n_pulse;
      logic [OUT_W-1:0] exp_first;
      logic [OUT_W-1:0] exp_last;
      logic             exp_done;
   } vec_t;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   en;
   logic signed [IN_W-1:0] din;
   logic                   din_valid;
   logic [OUT_W-1:0]       dout;
   logic                   dout_valid;
   logic                   status;
   logic                   busy;

   int               n_vec = 0;
   int               n_err = 0;
   int               cyc   = 0;
   longint           h [HLEN];
   int               hist [$];
   exp_t             exp_q [$];
   int               n_out;
   int               n_pulse;
   logic [OUT_W-1:0] first_dout;
   logic [OUT_W-1:0] last_dout;
   vec_t             vecs [5];

   xmpl_dsp_cic #(
      .IN_W      (IN_W),
      .STAGES    (STAGES),
      .DEC_R     (DEC_R),
      .FRAME_LEN (FRAME_LEN)
   ) dut (
      .clk_i                 (clk),
      .reset_i               (reset),
      .en_xmpl_dsp_cic_i     (en),
      .din_i                 (din),
      .din_valid_i           (din_valid),
      .dout_o                (dout),
      .dout_valid_o          (dout_valid),
      .xmpl_dsp_cic_status_o (status),
      .busy_o                (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(input string nm, input int d, input int g, input int na,
                               input int np, input int f, input int l, input logic dn);
      vec_t v;
      v.name = nm; v.din = d; v.gap = g; v.n_acc = na; v.n_pulse = np;
      v.exp_first = OUT_W'(f); v.exp_last = OUT_W'(l); v.exp_done = dn;
      return v;
   endfunction

   // Reference: direct convolution of the accepted history with the cascaded boxcar response.
   function automatic void model_accept(input logic signed [IN_W-1:0] d);
      longint acc;
      int     n;
      if (n_out >= FRAME_LEN) return;
      hist.push_back(int'(d));
      n = hist.size();
      if (n % DEC_R == 0) begin
         acc = 0;
         for (int j = 0; j < HLEN && j < n; j++) acc += h[j] * longint'(hist[n-1-j]);
         n_out++;
         exp_q.push_back('{OUT_W'(acc), cyc + 1, n_out == FRAME_LEN});
      end
   endfunction

   function automatic void session_clear();
      hist.delete();
      n_out   = 0;
      n_pulse = 0;
   endfunction

   task automatic drive(input logic signed [IN_W-1:0] d, input logic v);
      @(posedge clk); #1;
      din = d; din_valid = v;
      if (v && en) model_accept(d);
   endtask

   // Enable with a sample already presented; that IDLE-cycle sample must be ignored.
   task automatic start_session();
      @(posedge clk); #1;
      en = 1'b1; din = 16'sd100; din_valid = 1'b1;
      session_clear();
   endtask

   task automatic end_session(input string nm, input logic st_before);
      @(posedge clk); #1;
      en = 1'b0; din_valid = 1'b0;
      @(negedge clk);
      check({nm, "_status_hold"}, 64'(status), 64'(st_before));
      @(negedge clk);
      check({nm, "_status_clear"}, 64'(status), 64'd0);
      check({nm, "_busy_idle"}, 64'(busy), 64'd0);
      check({nm, "_missing_pulses"}, 64'(exp_q.size()), 64'd0);
   endtask

   // Output monitor: every pulse or expected pulse is matched against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      logic exp_now;
      exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (dout_valid || exp_now) begin
         check("dout_valid", 64'(dout_valid), 64'(exp_now));
         if (exp_now) begin
            e = exp_q.pop_front();
            if (dout_valid) begin
               check("dout", 64'(dout), 64'(e.val));
               check("status_with_pulse", 64'(status), 64'(e.st));
            end
         end
         if (dout_valid) begin
            n_pulse++;
            if (n_pulse == 1) first_dout = dout;
            last_dout = dout;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, n_vec %0d", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      longint tmp [HLEN];
      int     len;
      vec_t   t;

      for (int i = 0; i < HLEN; i++) h[i] = 0;
      h[0] = 1;
      len  = 1;
      repeat (STAGES) begin
         for (int i = 0; i < HLEN; i++) tmp[i] = 0;
         for (int i = 0; i < len; i++)
            for (int j = 0; j < DEC_R; j++) tmp[i+j] += h[i];
         len += DEC_R - 1;
         h = tmp;
      end

      vecs[0] = mk("step",     1,      1, 24,  3,  120,            512,       1'b0);
      vecs[1] = mk("full_neg", -1,     1, 520, 64, -120,           -512,      1'b1);
      vecs[2] = mk("gapped",   1,      3, 24,  3,  120,            512,       1'b0);
      vecs[3] = mk("max_pos",  32767,  1, 520, 64, 32767 * 120,    16776704,  1'b1);
      vecs[4] = mk("max_neg",  -32768, 1, 40,  5,  -32768 * 120,   -16777216, 1'b0);

      reset = 1'b1; en = 1'b0; din = '0; din_valid = 1'b0;
      session_clear();
      @(negedge clk);
      check("reset_dout", 64'(dout), 64'd0);
      check("reset_valid", 64'(dout_valid), 64'd0);
      check("reset_status", 64'(status), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("post_reset_dout", 64'(dout), 64'd0);
      check("post_reset_busy", 64'(busy), 64'd0);

      foreach (vecs[v]) begin
         t = vecs[v];
         start_session();
         for (int i = 0; i < t.n_acc; i++) begin
            drive(16'(t.din), 1'b1);
            for (int g = 1; g < t.gap; g++) drive(16'(t.din), 1'b0);
         end
         drive('0, 1'b0);
         drive('0, 1'b0);
         @(negedge clk);
         check({t.name, "_npulse"}, 64'(n_pulse), 64'(t.n_pulse));
         check({t.name, "_first"}, 64'(first_dout), 64'(t.exp_first));
         check({t.name, "_last"}, 64'(last_dout), 64'(t.exp_last));
         check({t.name, "_status"}, 64'(status), 64'(t.exp_done));
         check({t.name, "_busy"}, 64'(busy), 64'(!t.exp_done));
         end_session(t.name, t.exp_done);
      end

      // Abort five samples into the second group, then confirm a clean restart.
      start_session();
      for (int i = 0; i < DEC_R + 5; i++) drive(16'sd1, 1'b1);
      @(posedge clk); #1;
      en = 1'b0; din_valid = 1'b0;
      repeat (12) drive(16'sd1, 1'b0);
      @(negedge clk);
      check("abort_npulse", 64'(n_pulse), 64'd1);
      check("abort_status", 64'(status), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      start_session();
      for (int i = 0; i < 2 * DEC_R; i++) drive(16'sd1, 1'b1);
      drive('0, 1'b0);
      drive('0, 1'b0);
      @(negedge clk);
      check("restart_first", 64'(first_dout), 64'd120);
      check("restart_second", 64'(last_dout), 64'd456);
      end_session("restart", 1'b0);

      // Enable drop coinciding with the group-completing accept: no pulse.
      start_session();
      for (int i = 0; i < DEC_R - 1; i++) drive(16'sd1, 1'b1);
      @(posedge clk); #1;
      en = 1'b0; din = 16'sd1; din_valid = 1'b1;
      repeat (4) drive('0, 1'b0);
      @(negedge clk);
      check("abort_on_accept_npulse", 64'(n_pulse), 64'd0);
      check("abort_on_accept_busy", 64'(busy), 64'd0);

      // Enable drop coinciding with the final frame accept: no last pulse, no status.
      start_session();
      for (int i = 0; i < FRAME_LEN * DEC_R - 1; i++) drive(16'sd2, 1'b1);
      @(posedge clk); #1;
      en = 1'b0; din = 16'sd2; din_valid = 1'b1;
      repeat (4) drive('0, 1'b0);
      @(negedge clk);
      check("abort_on_last_npulse", 64'(n_pulse), 64'(FRAME_LEN - 1));
      check("abort_on_last_status", 64'(status), 64'd0);
      check("abort_on_last_last", 64'(last_dout), 64'd1024);

      // Asynchronous reset mid-frame: outputs clear before the next clock edge.
      start_session();
      for (int i = 0; i < DEC_R + 4; i++) drive(16'sd1, 1'b1);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check("async_rst_dout", 64'(dout), 64'd0);
      check("async_rst_valid", 64'(dout_valid), 64'd0);
      check("async_rst_status", 64'(status), 64'd0);
      check("async_rst_busy", 64'(busy), 64'd0);
      #1;
      reset = 1'b0; en = 1'b0; din_valid = 1'b0;
      exp_q.delete();
      session_clear();
      @(negedge clk);
      check("post_async_busy", 64'(busy), 64'd0);
      start_session();
      for (int i = 0; i < 3 * DEC_R; i++) drive(16'sd1, 1'b1);
      drive('0, 1'b0);
      drive('0, 1'b0);
      @(negedge clk);
      check("post_async_npulse", 64'(n_pulse), 64'd3);
      check("post_async_first", 64'(first_dout), 64'd120);
      check("post_async_last", 64'(last_dout), 64'd512);
      end_session("post_async", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
